// File: rtl/decode_pkg.sv
// Shared decode definitions: operation codes, condition codes, decoded field layout
// and the combinational instruction decoder used at the queue tail.
package decode_pkg;

  localparam logic [5:0] OP_ADD   = 6'd0;
  localparam logic [5:0] OP_ADDI  = 6'd1;
  localparam logic [5:0] OP_SUB   = 6'd2;
  localparam logic [5:0] OP_AND   = 6'd3;
  localparam logic [5:0] OP_ORR   = 6'd4;
  localparam logic [5:0] OP_EOR   = 6'd5;
  localparam logic [5:0] OP_MOV   = 6'd6;
  localparam logic [5:0] OP_MVN   = 6'd7;
  localparam logic [5:0] OP_CMP   = 6'd8;
  localparam logic [5:0] OP_TST   = 6'd9;
  localparam logic [5:0] OP_TEQ   = 6'd10;
  localparam logic [5:0] OP_BIC   = 6'd11;
  localparam logic [5:0] OP_MOVI  = 6'd12;
  localparam logic [5:0] OP_CMPI  = 6'd13;
  localparam logic [5:0] OP_B     = 6'd31;
  localparam logic [5:0] OP_BL    = 6'd32;
  localparam logic [5:0] OP_LDR   = 6'd41;
  localparam logic [5:0] OP_STR   = 6'd42;
  localparam logic [5:0] OP_UNDEF = 6'd63;

  typedef enum logic [3:0] {
    COND_EQ, COND_NE, COND_CS, COND_CC, COND_MI, COND_PL, COND_VS, COND_VC,
    COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_AL, COND_NV
  } cond_e;

  // Stored fields; the queue wraps this with the PC, whose width is a module parameter.
  typedef struct packed {
    logic [5:0]  op;
    logic [3:0]  cond;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [3:0]  rm;
    logic [7:0]  shift;
    logic [3:0]  rot;
    logic [7:0]  imm8;
    logic [11:0] off12;
    logic [23:0] br_off;
    logic        is_imm;
    logic        set_flags;
    logic        undef;
  } decoded_t;

  function automatic decoded_t decode(input logic [31:0] i);
    decoded_t d;
    d.op        = OP_UNDEF;
    d.cond      = i[31:28];
    d.rn        = i[19:16];
    d.rd        = i[15:12];
    d.rm        = i[3:0];
    d.shift     = i[11:4];
    d.rot       = i[11:8];
    d.imm8      = i[7:0];
    d.off12     = i[11:0];
    d.br_off    = i[23:0];
    d.is_imm    = 1'b0;
    d.set_flags = 1'b0;
    if (i[27:26] == 2'b00) begin
      d.is_imm    = i[25];
      d.set_flags = i[20];
      case (i[24:21])
        4'h0:    d.op = OP_AND;
        4'h1:    d.op = OP_EOR;
        4'h2:    d.op = OP_SUB;
        4'h4:    d.op = i[25] ? OP_ADDI : OP_ADD;
        4'h8:    d.op = OP_TST;
        4'h9:    d.op = OP_TEQ;
        4'hA:    d.op = i[25] ? OP_CMPI : OP_CMP;
        4'hC:    d.op = OP_ORR;
        4'hD:    d.op = i[25] ? OP_MOVI : OP_MOV;
        4'hE:    d.op = OP_BIC;
        4'hF:    d.op = OP_MVN;
        default: d.op = OP_UNDEF;
      endcase
    end else if (i[27:25] == 3'b101) begin
      d.op = i[24] ? OP_BL : OP_B;
    end else if (i[27:26] == 2'b01) begin
      d.is_imm = i[25];
      d.op     = i[20] ? OP_LDR : OP_STR;
      if (!i[20]) d.rm = i[15:12];
    end
    d.undef = (d.op == OP_UNDEF);
    return d;
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Condition-code pass/fail against NZCV flags; purely combinational so execute can reuse it.
module cond_eval
  import decode_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  always_comb begin
    pass = 1'b1;
    case (cond_e'(cond))
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      default: pass = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_queue.sv
// Registered decode stage: decodes at the tail, queues DEPTH entries, and evaluates
// the head condition against live flags. No combinational path from in_* to out_*.
module decode_queue
  import decode_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [ADDR_W-1:0]        in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_W-1:0]        out_pc,
  output logic [5:0]               out_op,
  output logic [3:0]               out_cond,
  output logic [3:0]               out_rn,
  output logic [3:0]               out_rd,
  output logic [3:0]               out_rm,
  output logic [7:0]               out_shift,
  output logic [3:0]               out_rot,
  output logic [7:0]               out_imm8,
  output logic [11:0]              out_off12,
  output logic [23:0]              out_br_off,
  output logic                     out_is_imm,
  output logic                     out_set_flags,
  output logic                     out_undef,
  input  logic [3:0]               flags,
  output logic                     out_exec,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    decoded_t          d;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           head_e;
  logic [PTR_W-1:0] head, tail;
  logic [PTR_W:0]   count;
  logic             full, push, pop;

  assign full      = (count == (PTR_W+1)'(DEPTH));
  assign in_ready  = !full && !reset;
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;
  assign occupancy = count;

  // Storage is reset too, so a freshly reset queue presents all-zero fields.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[tail] <= '{pc: in_pc, d: decode(in_instr)};
        tail      <= tail + PTR_W'(1);
      end
      if (pop) head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_e        = mem[head];
  assign out_pc        = head_e.pc;
  assign out_op        = head_e.d.op;
  assign out_cond      = head_e.d.cond;
  assign out_rn        = head_e.d.rn;
  assign out_rd        = head_e.d.rd;
  assign out_rm        = head_e.d.rm;
  assign out_shift     = head_e.d.shift;
  assign out_rot       = head_e.d.rot;
  assign out_imm8      = head_e.d.imm8;
  assign out_off12     = head_e.d.off12;
  assign out_br_off    = head_e.d.br_off;
  assign out_is_imm    = head_e.d.is_imm;
  assign out_set_flags = head_e.d.set_flags;
  assign out_undef     = head_e.d.undef;

  cond_eval u_cond_eval (
    .cond  (head_e.d.cond),
    .flags (flags),
    .pass  (out_exec)
  );

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: decode fields, ordering, backpressure, flush and async reset.
module tb_decode_queue;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc;
  logic        in_ready, out_valid;
  logic [5:0]  out_op;
  logic [3:0]  out_cond, out_rn, out_rd, out_rm, out_rot, flags;
  logic [7:0]  out_shift, out_imm8;
  logic [11:0] out_off12;
  logic [23:0] out_br_off;
  logic        out_is_imm, out_set_flags, out_undef, out_exec;
  logic [2:0]  occupancy;

  int checks = 0;
  int errors = 0;

  decode_queue #(.DEPTH(4), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_op(out_op),
    .out_cond(out_cond), .out_rn(out_rn), .out_rd(out_rd), .out_rm(out_rm),
    .out_shift(out_shift), .out_rot(out_rot), .out_imm8(out_imm8), .out_off12(out_off12),
    .out_br_off(out_br_off), .out_is_imm(out_is_imm), .out_set_flags(out_set_flags),
    .out_undef(out_undef), .flags(flags), .out_exec(out_exec), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1; in_instr = instr; in_pc = pc;
    cyc();
    in_valid = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0; flags = 4'b0000;
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_occ", occupancy, 0);
    cyc(); cyc();
    reset = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1);

    // ADD r5, r7, r6 appears one cycle after acceptance
    push(32'hE087_5006, 32'h100);
    chk("add_valid", out_valid, 1);
    chk("add_op", out_op, 0);
    chk("add_rn", out_rn, 7);
    chk("add_rd", out_rd, 5);
    chk("add_rm", out_rm, 6);
    chk("add_cond", out_cond, 4'hE);
    chk("add_exec", out_exec, 1);
    chk("add_pc", out_pc, 32'h100);
    chk("add_occ", occupancy, 1);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("add_pop_occ", occupancy, 0);

    // back-to-back ADDI, MOV, B with execute always ready
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'hE284_4001; in_pc = 32'h104;
    cyc();
    chk("addi_op", out_op, 1);
    chk("addi_imm8", out_imm8, 8'h01);
    chk("addi_is_imm", out_is_imm, 1);
    in_instr = 32'hE1A0_0003; in_pc = 32'h108;
    cyc();
    chk("mov_op", out_op, 6);
    chk("mov_rm", out_rm, 3);
    chk("mov_occ", occupancy, 1);
    in_instr = 32'hEA00_0000; in_pc = 32'h10C;
    cyc();
    chk("b_op", out_op, 31);
    chk("b_pc", out_pc, 32'h10C);
    in_valid = 1'b0;
    cyc();
    chk("b2b_drain_valid", out_valid, 0);
    out_ready = 1'b0;

    // ANDEQ against live flags
    push(32'h0000_0000, 32'h110);
    chk("andeq_op", out_op, 3);
    chk("andeq_exec_z0", out_exec, 0);
    flags = 4'b0100;
    #1;
    chk("andeq_exec_z1", out_exec, 1);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    flags = 4'b0000;

    // fill to DEPTH with execute stalled, fifth waits for a pop
    push(32'hE581_2003, 32'h200);
    push(32'hE0A0_0000, 32'h204);
    push(32'hEF00_0000, 32'h208);
    push(32'hE351_0005, 32'h20C);
    chk("full_occ", occupancy, 4);
    chk("full_in_ready", in_ready, 0);
    chk("str_op", out_op, 42);
    chk("str_rm", out_rm, 2);
    chk("str_pc", out_pc, 32'h200);
    in_valid = 1'b1; in_instr = 32'hE1E0_1002; in_pc = 32'h210;
    out_ready = 1'b1;
    #1;
    chk("full_pop_in_ready", in_ready, 0);
    cyc();
    chk("fifth_blocked_occ", occupancy, 3);
    chk("adc_pc", out_pc, 32'h204);
    chk("adc_op", out_op, 63);
    chk("adc_undef", out_undef, 1);
    cyc();
    in_valid = 1'b0;
    chk("fifth_accept_occ", occupancy, 3);
    chk("swi_pc", out_pc, 32'h208);
    chk("swi_undef", out_undef, 1);
    cyc();
    chk("cmpi_pc", out_pc, 32'h20C);
    chk("cmpi_op", out_op, 13);
    chk("cmpi_sf", out_set_flags, 1);
    chk("cmpi_imm8", out_imm8, 8'h05);
    chk("cmpi_occ", occupancy, 2);
    cyc();
    chk("mvn_pc", out_pc, 32'h210);
    chk("mvn_op", out_op, 7);
    chk("mvn_rd", out_rd, 1);
    cyc();
    chk("drain_occ", occupancy, 0);
    out_ready = 1'b0;

    // flush with occupancy 3 and a same-cycle push
    push(32'hE087_5006, 32'h300);
    push(32'hE087_5006, 32'h304);
    push(32'hE087_5006, 32'h308);
    chk("preflush_occ", occupancy, 3);
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'hE1A0_0003; in_pc = 32'h30C;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_occ", occupancy, 0);
    chk("flush_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    cyc();
    chk("flush_dropped_occ", occupancy, 0);

    // async reset mid-stream
    push(32'hE284_4001, 32'h400);
    push(32'hEA00_0000, 32'h404);
    chk("prerst_occ", occupancy, 2);
    #2;
    reset = 1'b1;
    #1;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_in_ready", in_ready, 0);
    chk("mrst_occ", occupancy, 0);
    chk("mrst_op", out_op, 0);
    chk("mrst_pc", out_pc, 0);
    chk("mrst_imm8", out_imm8, 0);
    chk("mrst_exec_z0", out_exec, 0);
    flags = 4'b0100;
    #1;
    chk("mrst_exec_z1", out_exec, 1);
    flags = 4'b0000;
    cyc(); cyc();
    reset = 1'b0;
    #1;
    chk("mrel_in_ready", in_ready, 1);
    push(32'hE791_2003, 32'h500);
    chk("ldr_op", out_op, 41);
    chk("ldr_off12", out_off12, 12'h003);
    chk("ldr_rn", out_rn, 1);
    chk("ldr_rd", out_rd, 2);
    chk("ldr_occ", occupancy, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
